// File: rtl/jtppi_mp_pkg.sv
// jtppi_mp_pkg
// Shared definitions for the multi-port PPI: register offsets inside a
// port's 4-register window, port mode encodings, and the bit positions of
// the CTRL and STATUS fields.
package jtppi_mp_pkg;

  // Register offsets (addr[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_DDR    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Port modes; encoding 3 is reserved and behaves as basic I/O
  typedef enum logic [1:0] {
    MODE_IO  = 2'd0,
    MODE_IN  = 2'd1,
    MODE_OUT = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  // CTRL fields
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_IE       = 2;

  // STATUS fields
  localparam int ST_OBF   = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

  // Mode actually in force for a stored CTRL mode field
  function automatic mode_e eff_mode(input logic [1:0] m);
    return (m == MODE_RSV) ? MODE_IO : mode_e'(m);
  endfunction

endpackage

// File: rtl/jtppi_mp_fifo.sv
// jtppi_mp_fifo
// Small synchronous FIFO used as the strobed-input buffer of one port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only if a pop happens in the same cycle
// (the pop frees the slot being written).
//
// Ports:
//   clk, rst      clock, async active-high reset
//   flush         empties the FIFO (wins over push/pop)
//   push, wdata   write request and data
//   pop           read request (ignored when empty)
//   head          oldest entry, valid when !empty
//   full, empty   occupancy flags
module jtppi_mp_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, push and pop hit the same slot; head is read before the
  // edge, so the popped value is delivered before it is overwritten.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jtppi_mp.sv
// jtppi_mp
// Multi-port parallel peripheral interface. NP identical DW-bit ports, each
// with a direction register and three modes: basic I/O, strobed input into
// a FIFO, and strobed output with an OBF/ACK handshake, plus a per-port
// level interrupt.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   addr                 {port index, register}; 0 DATA, 1 DDR, 2 CTRL, 3 STATUS
//   din / dout           CPU write data / registered CPU read data
//   rdn, wrn, csn        active-low CPU strobes
//   port_din             external pins, port p at [p*DW +: DW]
//   port_dout, port_oe   output latches and per-bit output enables
//   stb, ack             asynchronous input strobe / output acknowledge
//   obf, irq             output buffer full / interrupt request per port
module jtppi_mp
  import jtppi_mp_pkg::*;
#(
  parameter int NP    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(NP) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  input  logic             rdn,
  input  logic             wrn,
  input  logic             csn,
  input  logic [NP*DW-1:0] port_din,
  output logic [NP*DW-1:0] port_dout,
  output logic [NP*DW-1:0] port_oe,
  input  logic [NP-1:0]    stb,
  input  logic [NP-1:0]    ack,
  output logic [NP-1:0]    obf,
  output logic [NP-1:0]    irq
);

  logic          read, write, last_read, last_write;
  logic          wr_commit, rd_edge;
  logic [AW-1:0] port_sel;
  logic [1:0]    reg_sel;
  logic [DW-1:0] rd_val [NP];
  logic [DW-1:0] rd_word;

  assign read      = !rdn && !csn;
  assign write     = !wrn && !csn;
  // Writes commit on the trailing edge of the strobe; read side effects
  // happen once, on the leading edge.
  assign wr_commit = last_write && !write;
  assign rd_edge   = read && !last_read;
  assign port_sel  = addr >> 2;
  assign reg_sel   = addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_read  <= 1'b0;
      last_write <= 1'b0;
      dout       <= '1;
    end else begin
      last_read  <= read;
      last_write <= write;
      if (read) dout <= rd_word;
    end
  end

  // Unimplemented port indices read back as all ones.
  always_comb begin
    rd_word = '1;
    for (int i = 0; i < NP; i++) begin
      if (port_sel == AW'(i)) rd_word = rd_val[i];
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic          sel_here;
    logic          wr_data, wr_ddr, wr_ctrl, wr_stat;
    logic [DW-1:0] pin;
    logic [DW-1:0] latch, ddr, oe, rd_port;
    logic [1:0]    mode;
    mode_e         md;
    logic          ie, overflow, obf_r, irq_r;
    logic          stb_s1, stb_s2, stb_d;
    logic          ack_s1, ack_s2, ack_d;
    logic          stb_rise, ack_rise;
    logic          push, pop, ovf_evt;
    logic [DW-1:0] head;
    logic          full, empty;

    assign sel_here = (port_sel == AW'(p));
    assign wr_data  = wr_commit && sel_here && (reg_sel == REG_DATA);
    assign wr_ddr   = wr_commit && sel_here && (reg_sel == REG_DDR);
    assign wr_ctrl  = wr_commit && sel_here && (reg_sel == REG_CTRL);
    assign wr_stat  = wr_commit && sel_here && (reg_sel == REG_STATUS);
    assign pin      = port_din[p*DW +: DW];
    assign md       = eff_mode(mode);

    // Two-flop synchronisers plus an edge register for stb and ack
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stb_s1 <= 1'b0;
        stb_s2 <= 1'b0;
        stb_d  <= 1'b0;
        ack_s1 <= 1'b0;
        ack_s2 <= 1'b0;
        ack_d  <= 1'b0;
      end else begin
        stb_s1 <= stb[p];
        stb_s2 <= stb_s1;
        stb_d  <= stb_s2;
        ack_s1 <= ack[p];
        ack_s2 <= ack_s1;
        ack_d  <= ack_s2;
      end
    end

    assign stb_rise = stb_s2 && !stb_d;
    assign ack_rise = ack_s2 && !ack_d;

    assign push    = stb_rise && (md == MODE_IN);
    assign pop     = rd_edge && sel_here && (reg_sel == REG_DATA) && (md == MODE_IN) && !empty;
    // A pop in the same cycle makes room, so only an unmatched push overflows.
    assign ovf_evt = push && full && !pop;

    jtppi_mp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (wr_ctrl),
      .push  (push),
      .pop   (pop),
      .wdata (pin),
      .head  (head),
      .full  (full),
      .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        latch    <= '1;
        ddr      <= '0;
        mode     <= MODE_IO;
        ie       <= 1'b0;
        overflow <= 1'b0;
        obf_r    <= 1'b0;
        irq_r    <= 1'b0;
      end else begin
        if (wr_data) latch <= din;
        if (wr_ddr)  ddr   <= din;
        if (wr_ctrl) begin
          mode <= din[CTRL_IE-1:CTRL_MODE_LSB];
          ie   <= din[CTRL_IE];
        end

        // A fresh overflow in the same cycle as a STATUS clear is kept.
        if (wr_ctrl)                      overflow <= 1'b0;
        else if (ovf_evt)                 overflow <= 1'b1;
        else if (wr_stat && din[ST_OVF])  overflow <= 1'b0;

        // A DATA write beats a coincident ack edge.
        if (wr_ctrl)                            obf_r <= 1'b0;
        else if (wr_data && md == MODE_OUT)     obf_r <= 1'b1;
        else if (ack_rise && md == MODE_OUT)    obf_r <= 1'b0;

        irq_r <= ie && ((md == MODE_IN && !empty) || (md == MODE_OUT && !obf_r));
      end
    end

    always_comb begin
      case (md)
        MODE_IN:  oe = '0;
        MODE_OUT: oe = '1;
        default:  oe = ddr;
      endcase
    end

    always_comb begin
      rd_port = '0;
      case (reg_sel)
        REG_DATA: begin
          case (md)
            MODE_IN:  rd_port = empty ? pin : head;
            MODE_OUT: rd_port = latch;
            default:  rd_port = (latch & ddr) | (pin & ~ddr);
          endcase
        end
        REG_DDR: rd_port = ddr;
        REG_CTRL: begin
          rd_port[CTRL_IE]                 = ie;
          rd_port[CTRL_IE-1:CTRL_MODE_LSB] = mode;
        end
        default: begin
          rd_port[ST_OVF]   = overflow;
          rd_port[ST_FULL]  = full;
          rd_port[ST_EMPTY] = empty;
          rd_port[ST_OBF]   = obf_r;
        end
      endcase
    end

    assign rd_val[p]              = rd_port;
    assign port_dout[p*DW +: DW]  = latch;
    assign port_oe[p*DW +: DW]    = oe;
    assign obf[p]                 = obf_r;
    assign irq[p]                 = irq_r;
  end

endmodule

// File: tb/tb_jtppi_mp.sv
// tb_jtppi_mp
// Self-checking bench for jtppi_mp with three 8-bit ports (so port index 3
// is unimplemented) and 4-entry input FIFOs. A behavioural model holds each
// port's registers and its FIFO as a queue.
module tb_jtppi_mp;

  localparam int NP    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 4;

  localparam int R_DATA = 0, R_DDR = 1, R_CTRL = 2, R_STATUS = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    din, dout;
  logic             rdn, wrn, csn;
  logic [NP*DW-1:0] port_din, port_dout, port_oe;
  logic [NP-1:0]    stb, ack, obf, irq;
  logic [7:0]       pins [NP];

  assign port_din = {pins[2], pins[1], pins[0]};

  always #5 clk = ~clk;

  jtppi_mp #(
    .NP    (NP),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .rdn       (rdn),
    .wrn       (wrn),
    .csn       (csn),
    .port_din  (port_din),
    .port_dout (port_dout),
    .port_oe   (port_oe),
    .stb       (stb),
    .ack       (ack),
    .obf       (obf),
    .irq       (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_latch [NP];
  logic [7:0] m_ddr   [NP];
  logic [1:0] m_mode  [NP];
  logic       m_ie    [NP];
  logic       m_ovf   [NP];
  logic       m_obf   [NP];
  logic [7:0] m_q     [NP][$];

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_latch[p] = 8'hFF;
      m_ddr[p]   = 8'h00;
      m_mode[p]  = 2'd0;
      m_ie[p]    = 1'b0;
      m_ovf[p]   = 1'b0;
      m_obf[p]   = 1'b0;
      m_q[p].delete();
    end
  endfunction

  function automatic int meff(input int p);
    return (m_mode[p] == 2'd3) ? 0 : int'(m_mode[p]);
  endfunction

  function automatic void model_wr(input int p, input int r, input logic [7:0] d);
    if (p >= NP) return;
    case (r)
      R_DATA: begin
        m_latch[p] = d;
        if (meff(p) == 2) m_obf[p] = 1'b1;
      end
      R_DDR: m_ddr[p] = d;
      R_CTRL: begin
        m_mode[p] = d[1:0];
        m_ie[p]   = d[2];
        m_q[p].delete();
        m_obf[p]  = 1'b0;
        m_ovf[p]  = 1'b0;
      end
      default: if (d[3]) m_ovf[p] = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] model_rd(input int p, input int r);
    if (p >= NP) return 8'hFF;
    case (r)
      R_DATA: begin
        if (meff(p) == 1) return (m_q[p].size() == 0) ? pins[p] : m_q[p].pop_front();
        if (meff(p) == 2) return m_latch[p];
        return (m_latch[p] & m_ddr[p]) | (pins[p] & ~m_ddr[p]);
      end
      R_DDR:  return m_ddr[p];
      R_CTRL: return {5'b0, m_ie[p], m_mode[p]};
      default: return {4'b0, m_ovf[p], m_q[p].size() == DEPTH, m_q[p].size() == 0, m_obf[p]};
    endcase
  endfunction

  function automatic void model_push(input int p, input logic [7:0] d);
    if (meff(p) != 1) return;
    if (m_q[p].size() < DEPTH) m_q[p].push_back(d);
    else m_ovf[p] = 1'b1;
  endfunction

  function automatic void model_ack(input int p);
    if (meff(p) == 2) m_obf[p] = 1'b0;
  endfunction

  function automatic logic [7:0] exp_oe(input int p);
    if (meff(p) == 1) return 8'h00;
    if (meff(p) == 2) return 8'hFF;
    return m_ddr[p];
  endfunction

  function automatic logic exp_irq(input int p);
    return m_ie[p] && ((meff(p) == 1 && m_q[p].size() != 0) || (meff(p) == 2 && !m_obf[p]));
  endfunction

  // ---------------- bus and pin stimulus ----------------
  task automatic bus_wr(input int p, input int r, input logic [7:0] d);
    @(negedge clk);
    addr = AW'((p << 2) | r);
    din  = d;
    csn  = 1'b0;
    wrn  = 1'b0;
    @(negedge clk);
    wrn = 1'b1;
    csn = 1'b1;
    @(negedge clk);
    model_wr(p, r, d);
  endtask

  task automatic bus_rd(input int p, input int r, output logic [7:0] v);
    @(negedge clk);
    addr = AW'((p << 2) | r);
    csn  = 1'b0;
    rdn  = 1'b0;
    @(negedge clk);
    rdn = 1'b1;
    csn = 1'b1;
    v   = dout;
  endtask

  task automatic rd_chk(input string tag, input int p, input int r);
    logic [7:0] e, v;
    e = model_rd(p, r);
    bus_rd(p, r, v);
    chk(tag, v, e);
  endtask

  task automatic stb_pulse(input int p, input logic [7:0] d);
    @(negedge clk);
    pins[p] = d;
    stb[p]  = 1'b1;
    repeat (2) @(negedge clk);
    stb[p] = 1'b0;
    repeat (2) @(negedge clk);
    model_push(p, d);
  endtask

  task automatic ack_pulse(input int p);
    @(negedge clk);
    ack[p] = 1'b1;
    repeat (2) @(negedge clk);
    ack[p] = 1'b0;
    repeat (2) @(negedge clk);
    model_ack(p);
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      chk({tag, "/pdout"}, port_dout[p*8 +: 8], m_latch[p]);
      chk({tag, "/poe"},   port_oe[p*8 +: 8],   exp_oe(p));
      chk({tag, "/obf"},   obf[p],              m_obf[p]);
      chk({tag, "/irq"},   irq[p],              exp_irq(p));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    rst  = 1'b1;
    addr = '0;
    din  = '0;
    rdn  = 1'b1;
    wrn  = 1'b1;
    csn  = 1'b1;
    stb  = '0;
    ack  = '0;
    for (int p = 0; p < NP; p++) pins[p] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_pdout", port_dout, 24'hFFFFFF);
    chk("rst_poe",   port_oe,   24'h0);
    chk("rst_irq",   irq,       3'b0);
    chk("rst_obf",   obf,       3'b0);
    chk("rst_dout",  dout,      8'hFF);
    rd_chk("rst_status", 0, R_STATUS);

    // Mode 0 on port 1
    bus_wr(1, R_DDR, 8'h0F);
    bus_wr(1, R_DATA, 8'hA5);
    pins[1] = 8'h3C;
    chk("m0_oe",    port_oe[15:8],   8'h0F);
    chk("m0_pdout", port_dout[15:8], 8'hA5);
    rd_chk("m0_data", 1, R_DATA);
    rd_chk("m0_ddr",  1, R_DDR);

    // Reserved mode 3 behaves as basic I/O but reads back as written
    bus_wr(1, R_CTRL, 8'h03);
    check_all("m3");
    rd_chk("m3_ctrl", 1, R_CTRL);
    rd_chk("m3_data", 1, R_DATA);
    bus_wr(1, R_CTRL, 8'h00);

    // Mode 1 on port 2 with IE; first strobe timed through the synchroniser
    bus_wr(2, R_CTRL, 8'h05);
    rd_chk("m1_ctrl", 2, R_CTRL);
    check_all("m1_idle");
    @(negedge clk); pins[2] = 8'h11; stb[2] = 1'b1;
    @(negedge clk); chk("stb_irq_k",  irq[2], 1'b0);
    @(negedge clk); stb[2] = 1'b0; chk("stb_irq_k1", irq[2], 1'b0);
    @(negedge clk); chk("stb_irq_k2", irq[2], 1'b0);
    @(negedge clk); chk("stb_irq_k3", irq[2], 1'b1);
    model_push(2, 8'h11);
    for (int i = 2; i <= 5; i++) stb_pulse(2, 8'(i * 8'h11));
    rd_chk("m1_full_status", 2, R_STATUS);
    check_all("m1_full");
    for (int i = 0; i < 4; i++) rd_chk("m1_pop", 2, R_DATA);
    pins[2] = 8'hC3;
    rd_chk("m1_live", 2, R_DATA);
    rd_chk("m1_empty_status", 2, R_STATUS);
    check_all("m1_drained");
    bus_wr(2, R_STATUS, 8'h08);
    rd_chk("m1_ovf_clr", 2, R_STATUS);

    // Mode 2 on port 0 with IE
    bus_wr(0, R_CTRL, 8'h06);
    check_all("m2_idle");
    bus_wr(0, R_DATA, 8'h7E);
    chk("m2_obf_set", obf[0], 1'b1);
    check_all("m2_written");
    rd_chk("m2_data", 0, R_DATA);
    @(negedge clk); ack[0] = 1'b1;
    @(negedge clk); chk("ack_obf_k",  obf[0], 1'b1);
    @(negedge clk); ack[0] = 1'b0; chk("ack_obf_k1", obf[0], 1'b1);
    @(negedge clk); chk("ack_obf_k2", obf[0], 1'b0); chk("ack_irq_k2", irq[0], 1'b0);
    @(negedge clk); chk("ack_irq_k3", irq[0], 1'b1);
    model_ack(0);
    bus_wr(0, R_DATA, 8'h42);
    // DATA write commit coinciding with an ack edge
    @(negedge clk); ack[0] = 1'b1;
    @(negedge clk); addr = AW'(R_DATA); din = 8'h5A; csn = 1'b0; wrn = 1'b0;
    @(negedge clk); wrn = 1'b1; csn = 1'b1;
    @(negedge clk);
    model_wr(0, R_DATA, 8'h5A);
    chk("coincide_obf", obf[0], 1'b1);
    ack[0] = 1'b0;
    check_all("m2_coincide");

    // Simultaneous push and pop on a full FIFO, then flush via CTRL
    bus_wr(2, R_CTRL, 8'h01);
    for (int i = 0; i < 4; i++) stb_pulse(2, 8'($urandom_range(0, 255)));
    rd_chk("pp_full", 2, R_STATUS);
    @(negedge clk); pins[2] = 8'h99; stb[2] = 1'b1;
    @(negedge clk);
    @(negedge clk); stb[2] = 1'b0; addr = AW'((2 << 2) | R_DATA); csn = 1'b0; rdn = 1'b0;
    e = model_rd(2, R_DATA);
    @(negedge clk); rdn = 1'b1; csn = 1'b1;
    chk("pp_head", dout, e);
    model_push(2, 8'h99);
    @(negedge clk);
    rd_chk("pp_status", 2, R_STATUS);
    for (int i = 0; i < 4; i++) rd_chk("pp_drain", 2, R_DATA);
    for (int i = 0; i < 5; i++) stb_pulse(2, 8'($urandom_range(0, 255)));
    rd_chk("ovf_status", 2, R_STATUS);
    bus_wr(2, R_CTRL, 8'h01);
    rd_chk("flush_status", 2, R_STATUS);

    // Unimplemented port index
    bus_wr(3, R_DDR, 8'hFF);
    bus_wr(3, R_DATA, 8'h00);
    check_all("oor");
    rd_chk("oor_data", 3, R_DATA);
    rd_chk("oor_ctrl", 3, R_CTRL);

    // Randomised traffic: port 0 mode 2, port 1 mode 0, port 2 mode 1
    bus_wr(0, R_CTRL, 8'h06);
    bus_wr(1, R_CTRL, 8'h00);
    bus_wr(2, R_CTRL, 8'h05);
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0: bus_wr(1, R_DATA, 8'($urandom_range(0, 255)));
        1: bus_wr(1, R_DDR,  8'($urandom_range(0, 255)));
        2: begin pins[1] = 8'($urandom_range(0, 255)); rd_chk("rnd_m0", 1, R_DATA); end
        3: stb_pulse(2, 8'($urandom_range(0, 255)));
        4: begin pins[2] = 8'($urandom_range(0, 255)); rd_chk("rnd_m1", 2, R_DATA); end
        5: rd_chk("rnd_status", 2, R_STATUS);
        default: begin
          if ($urandom_range(0, 1) == 1) bus_wr(0, R_DATA, 8'($urandom_range(0, 255)));
          else ack_pulse(0);
        end
      endcase
      check_all("rnd");
    end

    // Reset during an in-flight strobe
    bus_wr(2, R_CTRL, 8'h05);
    rd_chk("prerst_read", 1, R_DDR);
    @(negedge clk); pins[2] = 8'h66; stb[2] = 1'b1;
    @(negedge clk); rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_pdout", port_dout, 24'hFFFFFF);
    chk("mid_rst_poe",   port_oe,   24'h0);
    chk("mid_rst_obf",   obf,       3'b0);
    chk("mid_rst_irq",   irq,       3'b0);
    chk("mid_rst_dout",  dout,      8'hFF);
    stb[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_all("post_rst");
    rd_chk("post_rst_status", 2, R_STATUS);
    rd_chk("post_rst_ctrl",   2, R_CTRL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtppi_mp.md
# jtppi_mp

Parametrised multi-port parallel peripheral interface, successor to the team's fixed 3×8-bit PPI. It provides NP identical ports of DW bits, each with a per-bit direction register and three modes: basic I/O, strobed input with a DEPTH-entry FIFO, and strobed output with an OBF/ACK handshake. Per-port interrupt requests are included. It sits on the CPU bus of an arcade/computer core and faces external peripheral pins.

## Interface
Parameters:
- NP, 4: number of ports (1..8).
- DW, 8: port width in bits.
- DEPTH, 4: input FIFO entries per port, power of 2, ≥2.
- AW, $clog2(NP)+2: CPU address width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  AW  {port index, reg[1:0]}; reg 0=DATA, 1=DDR, 2=CTRL, 3=STATUS.
- din  in  DW  CPU write data.
- dout  out  DW  CPU read data, registered.
- rdn, wrn, csn  in  1 each  active-low strobes; read = !rdn&&!csn, write = !wrn&&!csn.
- port_din  in  NP*DW  external input pins, port p at [p*DW +: DW].
- port_dout  out  NP*DW  output latches.
- port_oe  out  NP*DW  per-bit output enable.
- stb  in  NP  input strobe, asynchronous.
- ack  in  NP  output acknowledge, asynchronous.
- obf  out  NP  output buffer full, active-high.
- irq  out  NP  interrupt request per port, active-high.

## Operation
- Register writes commit on the cycle where write falls (last_write && !write), using addr/din of that cycle.
- Reads: dout loads every cycle read is high. Side effects happen once, on the read rising edge (read && !last_read).
- CTRL fields: [1:0] mode (0 basic, 1 strobed in, 2 strobed out, 3 treated as 0); [2] IE. CTRL reads return {0…, IE, mode}.
  - A CTRL write flushes the FIFO, clears obf and clears overflow.
  - A CTRL write rewriting the same mode also flushes.
- DDR: 1 = output. Read returns the DDR value.
- Mode 0:
  - port_oe = DDR; port_dout = latch.
  - DATA read returns latch on DDR=1 bits and port_din on DDR=0 bits.
  - DATA write loads latch.
- Mode 1:
  - port_oe forced to 0.
  - A synchronised stb rising edge pushes port_din into the FIFO.
  - DATA read returns the FIFO head and pops it on the read rising edge. An empty FIFO returns live port_din with no pop.
  - Push while full: data dropped, overflow set (sticky).
  - Push and pop in the same cycle: both occur, count unchanged. When full, the pop frees a slot and the push is accepted, with no overflow.
- Mode 2:
  - port_oe forced to all ones.
  - DATA write loads latch and sets obf.
  - A synchronised ack rising edge clears obf.
  - If a DATA write and an ack edge land in the same cycle, the write wins (obf=1).
  - DATA read returns latch.
- STATUS read: {0…, overflow, full, empty, obf}. Writing STATUS with din[3]=1 clears overflow; other bits are read-only.
- irq[p] = IE && ((mode1 && !empty) || (mode2 && !obf)). This is a registered level.
- Accesses to port index ≥ NP: writes ignored, reads return all ones.

## Timing
- Reset values:
  - latch all ones, DDR 0, mode 0, IE 0, FIFOs empty, overflow 0.
  - port_dout all ones, port_oe 0, obf 0, irq 0, dout all ones.
- stb and ack each pass through a 2-flop synchroniser plus an edge register. For a rising input sampled at clock edge k:
  - the push or obf clear happens at edge k+2;
  - the FIFO captures port_din present at edge k+2;
  - empty deasserts after edge k+2 and irq rises after edge k+3.
- Write commit happens at the edge after wrn/csn deassert. port_dout, port_oe and obf update at that same edge; irq follows one cycle later.
- Read data: dout is valid on the edge after read asserts. A FIFO pop takes effect at the same edge, so the next read returns the next entry.
- Reset asserted mid-transfer returns everything to the reset values immediately. A pending synchronised edge is discarded.

## Structure
- Shared include jtppi_pkg.vh holds:
  - register offsets (REG_DATA/DDR/CTRL/STATUS);
  - mode encodings (MODE_IO/IN/OUT);
  - STATUS and CTRL bit positions.
- Sub-module jtppi_fifo (DW, DEPTH):
  - synchronous FIFO with push, pop, head, full, empty;
  - pointers one bit wider than log2(DEPTH) for the full/empty distinction.
- Instantiate it NP times in a generate loop, together with the per-port synchronisers, handshake logic and registers.
- The top level muxes dout by port index.

## Test plan
- Reset: check port_dout=all ones, port_oe=0, irq=0, obf=0. Read STATUS on port 0 → 0x02 (empty).
- Mode 0 on port 1:
  - write DDR=0x0F, DATA=0xA5, and drive port_din[1]=0x3C;
  - required: port_oe=0x0F, port_dout=0xA5, DATA read → 0x35.
- Mode 1 on port 2 with IE, DEPTH=4:
  - pulse stb five times with data 0x11..0x55;
  - required: full=1, overflow=1, irq=1;
  - reads return 0x11,0x22,0x33,0x44, then live pins, then empty=1 and irq=0.
- Mode 2 on port 0 with IE:
  - write DATA=0x7E → obf=1, irq=0;
  - pulse ack → obf=0 at k+2, irq=1 at k+3;
  - a DATA write coinciding with an ack edge leaves obf=1.
- Simultaneous push and pop on a full FIFO → count stays 4, no overflow. A CTRL write then flushes → empty=1, overflow=0.
- Assert rst during an in-flight stb synchronisation → no push after release, all reset values restored.
